// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the RV32M divide sequencer.
// Contents:
//   div_state_t           - sequencer FSM states
//   F3_DIV..F3_REMU       - funct3 encodings of the four divide operations
//   DIV_OVF_RESULT        - most-negative 32-bit value (signed overflow quotient)
//   DIV_ALL_ONES          - all-ones word (divide-by-zero quotient, -1 divisor)
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } div_state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [31:0] DIV_OVF_RESULT = 32'h8000_0000;
  localparam logic [31:0] DIV_ALL_ONES   = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sequencer_if.sv
// Execute-stage <-> divide sequencer bundle.
// Signals:
//   start, funct3, SrcA, SrcB, RdIn, flush  - pipeline to sequencer
//   busy, stall, done, Result, RdOut        - sequencer to pipeline
// Modports: master = pipeline side, slave = sequencer side.
//
// Handshake: the sequencer takes an operation when it is idle and sees
// start high with flush low on a rising edge (no ready signal; start while
// busy is simply dropped). The result is valid only in the single cycle in
// which done is high; Result/RdOut keep that value until the next result
// is produced. flush kills any operation in flight without a done pulse.
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [4:0]      RdIn;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] Result;
  logic [4:0]      RdOut;

  modport master (
    output start, funct3, SrcA, SrcB, RdIn, flush,
    input  busy, stall, done, Result, RdOut
  );

  modport slave (
    input  start, funct3, SrcA, SrcB, RdIn, flush,
    output busy, stall, done, Result, RdOut
  );
endinterface

// File: rtl/div_sequencer_datapath.sv
// Radix-2 restoring divider datapath, sequenced by div_sequencer.
// Ports:
//   clk, rst          - clock, async active-high reset
//   i_load            - capture operand magnitudes, sign flags, operation, rd
//   i_shift           - perform one restoring iteration
//   i_fixup           - apply signs, select quotient/remainder into result
//   i_special         - load i_special_val and i_rd straight into the outputs
//   i_signed          - operation is DIV/REM
//   i_sel_rem         - operation returns the remainder
//   i_a, i_b, i_rd    - dividend, divisor, destination register
//   i_special_val     - precomputed result for divide-by-zero / overflow
//   o_result, o_rd    - registered result and its destination register
module div_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_shift,
  input  logic            i_fixup,
  input  logic            i_special,
  input  logic            i_signed,
  input  logic            i_sel_rem,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_special_val,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_result;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_sel_rem;
  logic [4:0]      r_rd;
  logic [4:0]      r_rd_out;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN:0]   w_shifted;
  logic            w_fits;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  assign w_a_neg = i_signed & i_a[XLEN-1];
  assign w_b_neg = i_signed & i_b[XLEN-1];

  // {rem,quo} shifted left by one; the partial remainder needs XLEN+1 bits.
  assign w_shifted = {r_rem, r_quo[XLEN-1]};
  // 33-bit trial subtract: a non-negative difference is the same as the
  // shifted remainder being >= divisor. When it fits, the true difference is
  // below the divisor, so the low XLEN bits of the subtraction are exact.
  assign w_fits    = (w_shifted >= {1'b0, r_div});
  assign w_diff    = w_shifted[XLEN-1:0] - r_div;

  assign w_quo_fix = r_neg_q ? (-r_quo) : r_quo;
  assign w_rem_fix = r_neg_r ? (-r_rem) : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_rd      <= '0;
      r_rd_out  <= '0;
    end else begin
      if (i_load) begin
        // Magnitudes only; 0x80000000 negates to itself, which is the
        // correct unsigned magnitude.
        r_quo     <= w_a_neg ? (-i_a) : i_a;
        r_div     <= w_b_neg ? (-i_b) : i_b;
        r_rem     <= '0;
        r_neg_q   <= w_a_neg ^ w_b_neg;
        r_neg_r   <= w_a_neg;
        r_sel_rem <= i_sel_rem;
        r_rd      <= i_rd;
      end else if (i_shift) begin
        r_quo <= {r_quo[XLEN-2:0], w_fits};
        r_rem <= w_fits ? w_diff : w_shifted[XLEN-1:0];
      end

      if (i_fixup) begin
        r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
        r_rd_out <= r_rd;
      end else if (i_special) begin
        r_result <= i_special_val;
        r_rd_out <= i_rd;
      end
    end
  end

  assign o_result = r_result;
  assign o_rd     = r_rd_out;

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer for the execute stage.
// Ports:
//   clk, rst     - clock, async active-high reset
//   bus          - div_sequencer_if slave: start/funct3/SrcA/SrcB/RdIn/flush
//                  in, busy/stall/done/Result/RdOut out
//   o_dbg_state  - current FSM state
// FSM: IDLE -> RUN (32 iterations) -> FIXUP -> DONE -> IDLE, or
// IDLE -> DONE directly for divide-by-zero and signed overflow.
module div_sequencer
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  div_sequencer_if.slave bus,
  output div_state_t     o_dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic             w_accept;
  logic             w_signed;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_special_val;
  logic             w_load;
  logic             w_shift;
  logic             w_fixup;
  logic             w_special_ld;

  // funct3[2] is set for every divide encoding; anything else is not ours.
  assign w_accept   = bus.start & ~bus.flush & bus.funct3[2];
  assign w_signed   = ~bus.funct3[0];
  assign w_div_zero = (bus.SrcB == '0);
  assign w_ovf      = w_signed & (bus.SrcA == DIV_OVF_RESULT) &
                      (bus.SrcB == DIV_ALL_ONES);
  assign w_special  = w_div_zero | w_ovf;

  // funct3[1] selects the remainder.
  always_comb begin
    w_special_val = '0;
    if (w_div_zero) begin
      w_special_val = bus.funct3[1] ? bus.SrcA : DIV_ALL_ONES;
    end else begin
      w_special_val = bus.funct3[1] ? '0 : DIV_OVF_RESULT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      if (w_load) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_fixup      = 1'b0;
    w_special_ld = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special) begin
            w_special_ld = 1'b1;
            w_next       = S_DONE;
          end else begin
            w_load = 1'b1;
            w_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          w_next = S_IDLE;
        end else begin
          w_shift = 1'b1;
          if (r_cnt == LAST_CNT) begin
            w_next = S_FIXUP;
          end
        end
      end
      S_FIXUP: begin
        if (bus.flush) begin
          w_next = S_IDLE;
        end else begin
          w_fixup = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  div_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_shift       (w_shift),
    .i_fixup       (w_fixup),
    .i_special     (w_special_ld),
    .i_signed      (w_signed),
    .i_sel_rem     (bus.funct3[1]),
    .i_a           (bus.SrcA),
    .i_b           (bus.SrcB),
    .i_rd          (bus.RdIn),
    .i_special_val (w_special_val),
    .o_result      (bus.Result),
    .o_rd          (bus.RdOut)
  );

  // Stall drops in DONE so the held instruction retires with the result.
  assign bus.stall = ((r_state == S_IDLE) & w_accept & ~w_special) |
                     (r_state == S_RUN) | (r_state == S_FIXUP);
  assign bus.done  = (r_state == S_DONE);
  assign bus.busy  = r_busy;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  import div_pkg::*;

  logic       clk;
  logic       rst;
  div_state_t dbg_state;

  div_sequencer_if #(.XLEN(32)) bus ();

  div_sequencer #(
    .XLEN (32),
    .CNT_W(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_rd  = 5'd0;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Drives one request at a negedge; returns at #1 after the sampling edge
  // (cycle 1). stall is checked in cycle 0 against the expected class.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic exp_stall0, input bit hold,
                       input string name);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.RdIn   = rd;
    #1;
    check({name, "_stall_c0"}, {31'd0, bus.stall}, {31'd0, exp_stall0});
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat,
                       input bit hold, input string name);
    int          cyc;
    int          got;
    int          err_cnt;
    int          done0;
    logic [31:0] want;
    exp_q.push_back(exp);
    issue(f3, a, b, rd, (lat != 1), hold, name);
    done0   = done_cnt;
    cyc     = 1;
    got     = -1;
    err_cnt = 0;
    while (cyc <= 60) begin
      if (bus.done === 1'b1) begin
        got = cyc;
        break;
      end
      if (bus.stall !== (lat != 1)) err_cnt++;
      if (bus.busy !== 1'b1) err_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (hold) bus.start = 1'b0;
    want = exp_q.pop_front();
    check({name, "_done_cycle"}, got, lat);
    check({name, "_result"}, bus.Result, want);
    check({name, "_rd"}, {27'd0, bus.RdOut}, {27'd0, rd});
    check({name, "_stall_done"}, {31'd0, bus.stall}, 32'd0);
    check({name, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
    check({name, "_stall_busy_run"}, err_cnt, 32'd0);
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({name, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
    check({name, "_done_count"}, done_cnt - done0, 32'd1);
    last_res = want;
    last_rd  = rd;
  endtask

  // ---------------- test ----------------
  initial begin
    int d0;

    vecs[0]  = '{F3_DIVU, 32'd100,        32'd7,        5'd1,  32'd14,         34, "divu_100_7"};
    vecs[1]  = '{F3_REMU, 32'd100,        32'd7,        5'd2,  32'd2,          34, "remu_100_7"};
    vecs[2]  = '{F3_DIV,  32'hFFFF_FFF9,  32'd2,        5'd3,  32'hFFFF_FFFD,  34, "div_m7_2"};
    vecs[3]  = '{F3_REM,  32'hFFFF_FFF9,  32'd2,        5'd4,  32'hFFFF_FFFF,  34, "rem_m7_2"};
    vecs[4]  = '{F3_REM,  32'd7,          32'hFFFF_FFFE, 5'd5, 32'd1,          34, "rem_7_m2"};
    vecs[5]  = '{F3_DIV,  32'd5,          32'd0,        5'd6,  32'hFFFF_FFFF,  1,  "div_5_0"};
    vecs[6]  = '{F3_REMU, 32'd5,          32'd0,        5'd7,  32'd5,          1,  "remu_5_0"};
    vecs[7]  = '{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd8, 32'h8000_0000,  1,  "div_ovf"};
    vecs[8]  = '{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd9, 32'd0,          1,  "rem_ovf"};
    vecs[9]  = '{F3_DIVU, 32'hFFFF_FFFF,  32'd1,        5'd10, 32'hFFFF_FFFF,  34, "divu_max_1"};
    vecs[10] = '{F3_DIV,  32'h8000_0000,  32'd2,        5'd11, 32'hC000_0000,  34, "div_min_2"};
    vecs[11] = '{F3_REMU, 32'h1234_5678,  32'h100,      5'd12, 32'h78,         34, "remu_hex"};
    vecs[12] = '{F3_DIVU, 32'd3,          32'd7,        5'd13, 32'd0,          34, "divu_small"};
    vecs[13] = '{F3_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 5'd14, 32'd3,         34, "div_m7_m2"};
    vecs[14] = '{F3_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFF, 34, "rem_m7_m2"};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.SrcA   = 32'd0;
    bus.SrcB   = 32'd0;
    bus.RdIn   = 5'd0;
    bus.flush  = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, bus.busy},   32'd0);
    check("rst_stall",  {31'd0, bus.stall},  32'd0);
    check("rst_done",   {31'd0, bus.done},   32'd0);
    check("rst_result", bus.Result,          32'd0);
    check("rst_rdout",  {27'd0, bus.RdOut},  32'd0);
    check("rst_state",  32'(dbg_state),      32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // table of directed vectors
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, 1'b0,
            vecs[i].name);
    end

    // flush in RUN cycle 10, then an immediately following op
    d0 = done_cnt;
    issue(F3_DIVU, 32'd1000, 32'd10, 5'd20, 1'b1, 1'b0, "flush_op");
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("flush_in_run", 32'(dbg_state), 32'(S_RUN));
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy",   {31'd0, bus.busy}, 32'd0);
    check("flush_done",   {31'd0, bus.done}, 32'd0);
    check("flush_state",  32'(dbg_state),    32'(S_IDLE));
    check("flush_result", bus.Result,        last_res);
    check("flush_rdout",  {27'd0, bus.RdOut}, {27'd0, last_rd});
    check("flush_no_done", done_cnt - d0,    32'd0);
    do_op(F3_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 34, 1'b0, "after_flush");

    // start held high for the whole operation: one done only
    do_op(F3_DIVU, 32'd50, 32'd5, 5'd22, 32'd10, 34, 1'b1, "held_start");
    d0 = done_cnt;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("held_no_restart", {31'd0, bus.busy}, 32'd0);

    // reset mid-RUN
    issue(F3_DIVU, 32'd9, 32'd3, 5'd23, 1'b1, 1'b0, "rst_op");
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("mid_in_run", 32'(dbg_state), 32'(S_RUN));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",   {31'd0, bus.busy},  32'd0);
    check("mid_rst_stall",  {31'd0, bus.stall}, 32'd0);
    check("mid_rst_done",   {31'd0, bus.done},  32'd0);
    check("mid_rst_result", bus.Result,         32'd0);
    check("mid_rst_rdout",  {27'd0, bus.RdOut}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    check("post_rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("post_rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("post_rst_no_done", done_cnt - d0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
